// File: rtl/core_pkg.sv
// core_pkg: shared ALU op codes, operand-select constants and datapath defaults
package core_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding and load-use/RAW hazard detection (IDEX_FORWARD_EN enables forwarding)
module hazard_fwd_unit
  import core_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  a_sel,
  input  logic                  b_sel,
  input  logic                  mem_write,
  output logic [XLEN-1:0]       fwd_rs1,
  output logic [XLEN-1:0]       fwd_rs2,
  output logic                  lu
);
  logic [2:0] hit1, hit2;
  logic       load_use;
`ifndef IDEX_FORWARD_EN
  logic unused_results;
  assign unused_results = ^{ex_alu_result, mem_result, wb_result};
`endif
  // writer matches per source ({WB, MEM, EX}), x0 never matches; then select operand and hazard
  always_comb begin
    hit1 = {wb_reg_write & (wb_rd == rs1_addr), mem_reg_write & (mem_rd == rs1_addr),
            ex_valid & ex_reg_write & (ex_rd == rs1_addr)} & {3{rs1_addr != '0}};
    hit2 = {wb_reg_write & (wb_rd == rs2_addr), mem_reg_write & (mem_rd == rs2_addr),
            ex_valid & ex_reg_write & (ex_rd == rs2_addr)} & {3{rs2_addr != '0}};
    load_use = ex_valid & ex_mem_read & (ex_rd != '0) & in_valid &
               (((ex_rd == rs1_addr) & ~a_sel) | ((ex_rd == rs2_addr) & (~b_sel | mem_write)));
`ifdef IDEX_FORWARD_EN
    fwd_rs1 = (hit1[0] & ~ex_mem_read) ? ex_alu_result : hit1[1] ? mem_result : hit1[2] ? wb_result : rs1_data;
    fwd_rs2 = (hit2[0] & ~ex_mem_read) ? ex_alu_result : hit2[1] ? mem_result : hit2[2] ? wb_result : rs2_data;
    lu      = load_use;
`else
    fwd_rs1 = rs1_data;
    fwd_rs2 = rs2_data;
    lu      = load_use | (in_valid & ((|hit1) | (|hit2)));
`endif
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand select, forwarding and hazard stall (IDEX_FORWARD_EN enables forwarding)
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       pc,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [3:0]            alu_op,
  input  logic                  a_sel,
  input  logic                  b_sel,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  flush,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       srcA,
  output logic [XLEN-1:0]       srcB,
  output logic [3:0]            op_code,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out
);
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            lu, adv;
  hazard_fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_hfu (
    .ex_valid(out_valid), .ex_rd(rd_out), .ex_reg_write(reg_write_out), .ex_mem_read(mem_read_out),
    .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result), .in_valid(in_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .a_sel(a_sel), .b_sel(b_sel), .mem_write(mem_write),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .lu(lu)
  );
  assign adv      = out_ready | ~out_valid;
  assign in_ready = flush | (adv & ~lu);
  // pipeline register: flush, then bubble on hazard, then capture/drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      srcA          <= '0;
      srcB          <= '0;
      op_code       <= ALU_ADD;
      store_data    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv & lu) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (adv & in_valid) begin
      out_valid     <= 1'b1;
      srcA          <= a_sel ? pc : fwd_rs1;
      srcB          <= b_sel ? imm : fwd_rs2;
      op_code       <= alu_op;
      store_data    <= fwd_rs2;
      rd_out        <= rd_addr;
      reg_write_out <= reg_write;
      mem_read_out  <= mem_read;
      mem_write_out <= mem_write;
    end else if (adv) begin
      out_valid <= 1'b0;
    end
  end
endmodule
